jtag_master: RTL and testbench
==============================

Name: jtag_master

Overview:
- JTAG initiator: the host-side driver that generates JTCK/JTMS/JTDI and samples JTDO, to drive the on-chip TAP target and its tar_controller.
- Accepts IR-scan, DR-scan and TAP-reset commands over a valid/ready interface.
- Walks the target TAP state machine from Run-Test/Idle and back.
- Returns the captured TDO bits as a one-cycle response.

Parameters:
- DIV, 2: JTCK half-period in system clock cycles (>=1); one JTAG bit = 2*DIV cycles.
- MAX_LEN, 32: maximum scan length in bits; width of CMD_DATA/RSP_DATA.
- LEN_W, 6: width of CMD_LEN; must hold MAX_LEN.

Ports:
- TCK  input  1  system clock; all logic on rising edge.
- TRST  input  1  asynchronous active-low reset.
- CMD_VALID  input  1  command request.
- CMD_READY  output  1  master idle and able to accept a command.
- CMD_OP  input  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=reserved (treated as 2).
- CMD_LEN  input  LEN_W  scan length in bits.
- CMD_DATA  input  MAX_LEN  TDI bits; bit0 is shifted first.
- RSP_VALID  output  1  one-cycle pulse when a command completes.
- RSP_DATA  output  MAX_LEN  captured TDO bits, bit0 = first captured; unused upper bits 0.
- JTCK  output  1  JTAG clock to target.
- JTMS  output  1  JTAG mode select.
- JTDI  output  1  JTAG data to target.
- JTDO  input  1  JTAG data from target.

Behaviour:
- Reset values (TRST low, asynchronous): JTCK=0, JTMS=1, JTDI=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0, state=INIT.
- Bit timing:
  - Each JTAG bit has a low phase (DIV cycles, JTCK=0) followed by a high phase (DIV cycles, JTCK=1).
  - JTMS/JTDI change only on the first cycle of the low phase.
  - JTDO is sampled on the cycle JTCK rises.
- States and TMS per bit:
  - INIT: TMS=1 x5, then TMS=0 x1 -> IDLE.
  - IDLE: JTCK=0, JTMS=0, CMD_READY=1.
  - SEL_DR: TMS=1.
  - SEL_IR: TMS=1, IR only.
  - CAPTURE: TMS=0.
  - ENTER_SHIFT: TMS=0.
  - SHIFT: N bits, TMS=0 except last bit TMS=1.
  - UPDATE: TMS=1.
  - RTI: TMS=0.
  - Then back to IDLE.
- Edge counts per command:
  - DR scan: N+5 JTCK rising edges.
  - IR scan: N+6 JTCK rising edges.
  - Reset: 6 edges (same sequence as INIT).
- SHIFT data:
  - JTDI = CMD_DATA[i] during bit i, LSB first.
  - JTDO sampled at bit i's rising edge -> RSP_DATA[i].
  - JTDI=0 outside SHIFT.
- Handshake:
  - Command is accepted on the cycle CMD_VALID && CMD_READY; command fields are registered then.
  - CMD_READY drops the next cycle.
  - The first JTAG bit low phase starts the cycle after acceptance.
- Completion:
  - RSP_VALID pulses 1 cycle after the final high phase ends.
  - CMD_READY reasserts in the same cycle as RSP_VALID.
  - RSP_DATA holds its value until the next completion.
  - For a reset command, RSP_DATA=0.
- Boundary conditions:
  - CMD_LEN=0 on a scan: no JTAG activity; RSP_VALID the cycle after acceptance; RSP_DATA=0.
  - CMD_LEN>MAX_LEN: clamped to MAX_LEN.
  - CMD_VALID while busy: ignored; CMD_VALID held across completion is accepted on the first CMD_READY cycle, so back-to-back commands have exactly 1 idle cycle between them.
  - TRST asserted mid-operation: immediate reset, the command is dropped with no response, and INIT reruns after release.
- Counters: the phase counter counts 0..DIV-1; the bit counter is LEN_W bits wide.

Decomposition:
- Package jtag_pkg:
  - master state enum.
  - CMD_OP encodings.
  - INIT_TMS_ONES = 5.
- Sub-module jtag_tick_gen:
  - Phase counter producing JTCK and one-cycle fall_stb/rise_stb strobes.
  - Enabled only when not IDLE.
  - Reset to JTCK=0.

Test Plan:
- Release TRST, DIV=2 -> 6 JTCK pulses with JTMS=1,1,1,1,1,0, each 4 cycles long; then CMD_READY=1, JTCK stays 0.
- DR scan, LEN=8, DATA=0xA5, JTDO looped to JTDI -> 13 edges; JTMS = 1,0,0,0000000,1,1,0; RSP_DATA=0xA5; one RSP_VALID pulse.
- IR scan, LEN=4, DATA=0x3, JTDO tied 1 -> 10 edges; JTMS starts 1,1,0,0; RSP_DATA=0xF.
- CMD_LEN=0 -> no JTCK edge; RSP_VALID 1 cycle after accept; RSP_DATA=0. CMD_LEN=40 with MAX_LEN=32 -> 37 edges.
- Two DR commands with CMD_VALID held -> second accepted on first CMD_READY cycle; exactly 1 idle cycle between them.
- TRST pulsed during SHIFT bit 3 -> outputs at reset values immediately, no RSP_VALID, then the INIT sequence. Repeat with DIV=1 -> bit = 2 cycles.

Source files
------------

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared types and constants for the JTAG master
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_TLR,
        ST_SEL_DR,
        ST_SEL_IR,
        ST_CAPTURE,
        ST_ENTER_SHIFT,
        ST_SHIFT,
        ST_UPDATE,
        ST_RTI
    } state_e;

    typedef enum logic [1:0] {
        OP_DR    = 2'd0,
        OP_IR    = 2'd1,
        OP_RESET = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_e;

    localparam int INIT_TMS_ONES = 5;

endpackage

// File: rtl/jtag_if.sv
// rtl/jtag_if.sv - command/response channel between a host and the JTAG master
interface jtag_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [LEN_W-1:0]   cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_tick_gen.sv
// rtl/jtag_tick_gen.sv - JTCK phase generator; strobes mark the cycle whose closing edge makes JTCK rise or fall
module jtag_tick_gen #(
    parameter int DIV = 2
) (
    input  logic tck_i,
    input  logic trst_ni,
    input  logic en_i,
    output logic jtck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);
    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PH_W-1:0] ph_q, ph_d;
    logic            high_q, high_d;
    logic            wrap;

    assign wrap = (ph_q == PH_W'(DIV - 1));

    always_comb begin
        ph_d   = ph_q;
        high_d = high_q;
        if (!en_i) begin
            ph_d   = '0;
            high_d = 1'b0;
        end else if (wrap) begin
            ph_d   = '0;
            high_d = ~high_q;
        end else begin
            ph_d = ph_q + 1'b1;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ph_q   <= '0;
            high_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            high_q <= high_d;
        end
    end

    assign jtck_o     = high_q;
    assign rise_stb_o = en_i && !high_q && wrap;
    assign fall_stb_o = en_i && high_q && wrap;
endmodule

// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - JTAG initiator: runs IR/DR scans and TAP resets, returns captured TDO bits
module jtag_master #(
    parameter int DIV     = 2,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic tck_i,
    input  logic trst_ni,
    jtag_if.master bus,
    output logic jtck_o,
    output logic jtms_o,
    output logic jtdi_o,
    input  logic jtdo_i
);
    import jtag_pkg::*;

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
    logic               is_ir_q, is_ir_d;
    logic [MAX_LEN-1:0] data_q, data_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
    logic               jtms_q, jtms_d, jtdi_q, jtdi_d, rsp_valid_q, rsp_valid_d;
    logic               rise_stb, fall_stb, accept, new_bit;
    logic [LEN_W-1:0]   len_clamped;
    cmd_op_e            op;

    jtag_tick_gen #(.DIV(DIV)) u_tick (
        .tck_i     (tck_i),
        .trst_ni   (trst_ni),
        .en_i      (state_q != ST_IDLE),
        .jtck_o    (jtck_o),
        .rise_stb_o(rise_stb),
        .fall_stb_o(fall_stb)
    );

    assign op          = cmd_op_e'(bus.cmd_op);
    assign accept      = bus.cmd_valid && (state_q == ST_IDLE);
    assign len_clamped = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;

    function automatic logic tms_for(state_e st, logic [LEN_W-1:0] cnt, logic [LEN_W-1:0] len);
        case (st)
            ST_INIT, ST_TLR:                 tms_for = (cnt < LEN_W'(INIT_TMS_ONES));
            ST_SEL_DR, ST_SEL_IR, ST_UPDATE: tms_for = 1'b1;
            ST_SHIFT:                        tms_for = (cnt == len - 1'b1);
            default:                         tms_for = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        is_ir_d     = is_ir_q;
        data_d      = data_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        jtms_d      = jtms_q;
        jtdi_d      = jtdi_q;
        new_bit     = 1'b0;

        if (accept) begin
            data_d  = bus.cmd_data;
            len_d   = len_clamped;
            is_ir_d = (op == OP_IR);
            rx_d    = '0;
            cnt_d   = '0;
            if (op == OP_DR || op == OP_IR) begin
                if (len_clamped == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    state_d = ST_SEL_DR;
                    new_bit = 1'b1;
                end
            end else begin
                state_d = ST_TLR;
                new_bit = 1'b1;
            end
        end

        if (rise_stb && state_q == ST_SHIFT) begin
            rx_d[IDX_W'(cnt_q)] = jtdo_i;
        end

        // State advances at the end of each bit so the next TMS/TDI lands on the first low cycle
        if (fall_stb) begin
            new_bit = 1'b1;
            case (state_q)
                ST_INIT, ST_TLR: begin
                    if (cnt_q == LEN_W'(INIT_TMS_ONES)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (state_q == ST_TLR) begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = rx_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SEL_DR:      state_d = is_ir_q ? ST_SEL_IR : ST_CAPTURE;
                ST_SEL_IR:      state_d = ST_CAPTURE;
                ST_CAPTURE:     state_d = ST_ENTER_SHIFT;
                ST_ENTER_SHIFT: begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
                ST_SHIFT: begin
                    if (cnt_q == len_q - 1'b1) state_d = ST_UPDATE;
                    else                       cnt_d   = cnt_q + 1'b1;
                end
                ST_UPDATE:      state_d = ST_RTI;
                ST_RTI: begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end
                default:        state_d = ST_IDLE;
            endcase
        end

        if (new_bit) begin
            jtms_d = tms_for(state_d, cnt_d, len_d);
            jtdi_d = (state_d == ST_SHIFT) ? data_d[IDX_W'(cnt_d)] : 1'b0;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            len_q       <= '0;
            is_ir_q     <= 1'b0;
            data_q      <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            jtms_q      <= 1'b1;
            jtdi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            is_ir_q     <= is_ir_d;
            data_q      <= data_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            jtms_q      <= jtms_d;
            jtdi_q      <= jtdi_d;
        end
    end

    assign jtms_o        = jtms_q;
    assign jtdi_o        = jtdi_q;
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - directed self-checking bench for jtag_master (DIV=2 and DIV=1 instances)
module tb_jtag_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic trst_a, trst_b;
    logic jtck_a, jtms_a, jtdi_a, jtdo_a;
    logic jtck_b, jtms_b, jtdi_b, jtdo_b;
    logic loop_a = 1'b1;
    logic tie_a  = 1'b0;

    int checks = 0;
    int failures = 0;
    int edges_a = 0, edges_b = 0, rsp_cnt_a = 0, rsp_cnt_b = 0;
    logic tms_log [0:255];
    logic tdi_log [0:255];

    jtag_if #(.MAX_LEN(32), .LEN_W(6)) bus_a ();
    jtag_if #(.MAX_LEN(32), .LEN_W(6)) bus_b ();

    assign jtdo_a = loop_a ? jtdi_a : tie_a;
    assign jtdo_b = jtdi_b;

    jtag_master #(.DIV(2), .MAX_LEN(32), .LEN_W(6)) dut_a (
        .tck_i(clk), .trst_ni(trst_a), .bus(bus_a),
        .jtck_o(jtck_a), .jtms_o(jtms_a), .jtdi_o(jtdi_a), .jtdo_i(jtdo_a)
    );

    jtag_master #(.DIV(1), .MAX_LEN(32), .LEN_W(6)) dut_b (
        .tck_i(clk), .trst_ni(trst_b), .bus(bus_b),
        .jtck_o(jtck_b), .jtms_o(jtms_b), .jtdi_o(jtdi_b), .jtdo_i(jtdo_b)
    );

    always @(posedge jtck_a) begin
        tms_log[edges_a[7:0]] = jtms_a;
        tdi_log[edges_a[7:0]] = jtdi_a;
        edges_a++;
    end

    always @(posedge jtck_b) edges_b++;

    always @(posedge clk) begin
        if (bus_a.rsp_valid === 1'b1) rsp_cnt_a++;
        if (bus_b.rsp_valid === 1'b1) rsp_cnt_b++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_log(input int first, input int n, input bit use_tdi);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[62:0], use_tdi ? tdi_log[8'(first + i)] : tms_log[8'(first + i)]};
        end
        return v;
    endfunction

    task automatic cmd_a(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         output int lat, output int ne, output logic [31:0] rd, output int e0);
        int k;
        k = 0;
        while (bus_a.cmd_ready !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        bus_a.cmd_op    = op;
        bus_a.cmd_len   = len;
        bus_a.cmd_data  = data;
        bus_a.cmd_valid = 1'b1;
        e0 = edges_a;
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        k = 1;
        while (bus_a.rsp_valid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        lat = k;
        ne  = edges_a - e0;
        rd  = bus_a.rsp_data;
    endtask

    task automatic reset_vals_a(input string tag);
        chk({tag, "_jtck"}, 64'(jtck_a), 64'd0);
        chk({tag, "_jtms"}, 64'(jtms_a), 64'd1);
        chk({tag, "_jtdi"}, 64'(jtdi_a), 64'd0);
        chk({tag, "_ready"}, 64'(bus_a.cmd_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus_a.rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(bus_a.rsp_data), 64'd0);
    endtask

    initial begin
        int n, k, lat, ne, e0, r0;
        logic [31:0] rd, rd1;

        trst_a = 1'b0;
        trst_b = 1'b0;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_op = 2'd0; bus_a.cmd_len = '0; bus_a.cmd_data = '0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = 2'd0; bus_b.cmd_len = '0; bus_b.cmd_data = '0;
        repeat (3) @(negedge clk);
        reset_vals_a("rst");

        // INIT after release: 6 bits of 4 cycles, TMS 111110
        trst_a = 1'b1;
        n = 0;
        while (bus_a.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("init_ready_cycles", 64'(n), 64'd24);
        chk("init_edges", 64'(edges_a), 64'd6);
        chk("init_tms", pack_log(0, 6, 1'b0), 64'b111110);
        repeat (3) @(negedge clk);
        chk("idle_jtck", 64'(jtck_a), 64'd0);
        chk("init_no_rsp", 64'(rsp_cnt_a), 64'd0);

        // DR scan, loopback
        r0 = rsp_cnt_a;
        cmd_a(2'd0, 6'd8, 32'hA5, lat, ne, rd, e0);
        chk("dr_latency", 64'(lat), 64'd53);
        chk("dr_edges", 64'(ne), 64'd13);
        chk("dr_rsp", 64'(rd), 64'hA5);
        chk("dr_tms", pack_log(e0, 13, 1'b0), 64'b1000000000110);
        chk("dr_ready_with_rsp", 64'(bus_a.cmd_ready), 64'd1);
        @(negedge clk);
        chk("dr_rsp_pulse_drop", 64'(bus_a.rsp_valid), 64'd0);
        chk("dr_rsp_count", 64'(rsp_cnt_a - r0), 64'd1);

        // IR scan, TDO tied high
        loop_a = 1'b0; tie_a = 1'b1;
        cmd_a(2'd1, 6'd4, 32'h3, lat, ne, rd, e0);
        chk("ir_latency", 64'(lat), 64'd41);
        chk("ir_edges", 64'(ne), 64'd10);
        chk("ir_rsp", 64'(rd), 64'hF);
        chk("ir_tms", pack_log(e0, 10, 1'b0), 64'b1100000110);
        chk("ir_tdi", pack_log(e0, 10, 1'b1), 64'b0000110000);
        repeat (4) @(negedge clk);
        chk("ir_rsp_hold", 64'(bus_a.rsp_data), 64'hF);
        loop_a = 1'b1;

        // Zero length and clamped length
        cmd_a(2'd0, 6'd0, 32'hFF, lat, ne, rd, e0);
        chk("len0_latency", 64'(lat), 64'd1);
        chk("len0_edges", 64'(ne), 64'd0);
        chk("len0_rsp", 64'(rd), 64'd0);
        @(negedge clk);
        cmd_a(2'd0, 6'd40, 32'hDEADBEEF, lat, ne, rd, e0);
        chk("clamp_latency", 64'(lat), 64'd149);
        chk("clamp_edges", 64'(ne), 64'd37);
        chk("clamp_rsp", 64'(rd), 64'hDEADBEEF);

        // TAP reset commands (op 2 and reserved op 3)
        cmd_a(2'd2, 6'd8, 32'h55, lat, ne, rd, e0);
        chk("tlr_latency", 64'(lat), 64'd25);
        chk("tlr_edges", 64'(ne), 64'd6);
        chk("tlr_rsp", 64'(rd), 64'd0);
        chk("tlr_tms", pack_log(e0, 6, 1'b0), 64'b111110);
        @(negedge clk);
        cmd_a(2'd3, 6'd5, 32'h1, lat, ne, rd, e0);
        chk("rsvd_edges", 64'(ne), 64'd6);

        // Back-to-back with CMD_VALID held across completion
        @(negedge clk);
        bus_a.cmd_op = 2'd0; bus_a.cmd_len = 6'd8; bus_a.cmd_data = 32'h12; bus_a.cmd_valid = 1'b1;
        k = 0;
        while (bus_a.rsp_valid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        rd1 = bus_a.rsp_data;
        chk("b2b_first_latency", 64'(k), 64'd53);
        chk("b2b_first_rsp", 64'(rd1), 64'h12);
        chk("b2b_idle_ready", 64'(bus_a.cmd_ready), 64'd1);
        bus_a.cmd_data = 32'h34;
        @(negedge clk);
        chk("b2b_ready_drop", 64'(bus_a.cmd_ready), 64'd0);
        bus_a.cmd_valid = 1'b0;
        k = 1;
        while (bus_a.rsp_valid !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        chk("b2b_second_latency", 64'(k), 64'd53);
        chk("b2b_second_rsp", 64'(bus_a.rsp_data), 64'h34);

        // TRST during SHIFT bit 3 (DIV=2)
        @(negedge clk);
        r0 = rsp_cnt_a;
        bus_a.cmd_op = 2'd0; bus_a.cmd_len = 6'd8; bus_a.cmd_data = 32'hFF; bus_a.cmd_valid = 1'b1;
        e0 = edges_a;
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        k = 0;
        while (edges_a - e0 < 6 && k < 100) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        chk("pre_trst_jtdi", 64'(jtdi_a), 64'd1);
        trst_a = 1'b0;
        #1;
        reset_vals_a("trst");
        repeat (3) @(negedge clk);
        trst_a = 1'b1;
        e0 = edges_a;
        n = 0;
        while (bus_a.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("reinit_ready_cycles", 64'(n), 64'd24);
        chk("reinit_edges", 64'(edges_a - e0), 64'd6);
        chk("reinit_tms", pack_log(e0, 6, 1'b0), 64'b111110);
        chk("trst_no_rsp", 64'(rsp_cnt_a - r0), 64'd0);

        // DIV=1 instance: 2-cycle bits
        trst_b = 1'b1;
        n = 0;
        while (bus_b.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("b_init_ready_cycles", 64'(n), 64'd12);
        chk("b_init_edges", 64'(edges_b), 64'd6);
        bus_b.cmd_op = 2'd0; bus_b.cmd_len = 6'd4; bus_b.cmd_data = 32'h6; bus_b.cmd_valid = 1'b1;
        e0 = edges_b;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        k = 1;
        while (bus_b.rsp_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("b_dr_latency", 64'(k), 64'd19);
        chk("b_dr_edges", 64'(edges_b - e0), 64'd9);
        chk("b_dr_rsp", 64'(bus_b.rsp_data), 64'h6);

        @(negedge clk);
        r0 = rsp_cnt_b;
        bus_b.cmd_op = 2'd0; bus_b.cmd_len = 6'd4; bus_b.cmd_data = 32'hF; bus_b.cmd_valid = 1'b1;
        e0 = edges_b;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        k = 0;
        while (edges_b - e0 < 6 && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        chk("b_pre_trst_jtdi", 64'(jtdi_b), 64'd1);
        trst_b = 1'b0;
        #1;
        chk("b_trst_jtck", 64'(jtck_b), 64'd0);
        chk("b_trst_jtms", 64'(jtms_b), 64'd1);
        chk("b_trst_ready", 64'(bus_b.cmd_ready), 64'd0);
        chk("b_trst_rsp_data", 64'(bus_b.rsp_data), 64'd0);
        repeat (2) @(negedge clk);
        trst_b = 1'b1;
        e0 = edges_b;
        n = 0;
        while (bus_b.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("b_reinit_ready_cycles", 64'(n), 64'd12);
        chk("b_reinit_edges", 64'(edges_b - e0), 64'd6);
        chk("b_trst_no_rsp", 64'(rsp_cnt_b - r0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
